axi_lite_sram_slave: RTL and testbench

- AXI4-Lite responder (slave) backing a word-addressed, byte-writable SRAM.
- Serves the read and write channels driven by the core's fetch and load/store masters.
- Read and write paths run as independent FSMs with programmable response latency, to exercise master wait states.
- Out-of-range addresses return SLVERR.

---
 rtl/axi_lite_sram_slave.sv | 245 ++++++++++++++++++++++++
 tb/tb_axi_lite_sram_slave.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder in front of a word-addressed, byte-writable SRAM.
// The read and write channels are independent FSMs. Each one waits a fixed,
// parameterised number of cycles before it responds, so that masters see
// wait states. An address outside the window gets an SLVERR response.
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LAT     = 2,
    parameter int          WR_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr_i,
    input  logic        arvalid_i,
    output logic        arready_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  rresp_o,
    output logic        rvalid_o,
    input  logic        rready_i,
    input  logic [31:0] awaddr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  wstrb_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [1:0]  bresp_o,
    output logic        bvalid_o,
    input  logic        bready_i
);

    localparam int          WORDS     = 1 << DEPTH_LOG2;
    localparam logic [32:0] WIN_BYTES = 33'(4) << DEPTH_LOG2;
    localparam logic [3:0]  RD_CNT    = 4'(RD_LAT);
    localparam logic [3:0]  WR_CNT    = 4'(WR_LAT);
    localparam logic [1:0]  OKAY      = 2'b00;
    localparam logic [1:0]  SLVERR    = 2'b10;

    // The latency counters are 4 bits wide. A latency outside 0..15 would be truncated silently, so it is rejected here.
    generate
        if (RD_LAT < 0 || RD_LAT > 15 || WR_LAT < 0 || WR_LAT > 15) begin : g_bad_lat
            $error("axi_lite_sram_slave: RD_LAT/WR_LAT must be in 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;
    typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_WAIT, W_RESP} wstate_t;

    logic [31:0] mem [WORDS];

    // ---------------- read channel ----------------
    rstate_t     rstate_q, rstate_d;
    logic [3:0]  rcnt_q, rcnt_d;
    logic [31:0] raddr_q, raddr_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic                  ar_hs, r_hs, r_in;
    logic [31:0]           roff;
    logic [DEPTH_LOG2-1:0] r_idx;

    assign ar_hs = arvalid_i && arready_q;
    assign r_hs  = rvalid_q && rready_i;
    // The subtraction wraps. An address below BASE therefore becomes a large offset and falls out of range.
    assign roff  = raddr_q - BASE;
    assign r_in  = {1'b0, roff} < WIN_BYTES;
    assign r_idx = roff[DEPTH_LOG2+1:2];

    // Read state and registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate_q  <= R_IDLE;
            rcnt_q    <= '0;
            raddr_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            rstate_q  <= rstate_d;
            rcnt_q    <= rcnt_d;
            raddr_q   <= raddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Read next state: capture the address, count the wait cycles, then hold the response until it is accepted.
    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        raddr_d  = raddr_q;
        case (rstate_q)
            R_IDLE: if (ar_hs) begin
                raddr_d  = araddr_i;
                rcnt_d   = RD_CNT;
                rstate_d = (RD_LAT == 0) ? R_RESP : R_WAIT;
            end
            R_WAIT: begin
                rcnt_d = rcnt_q - 4'd1;
                if (rcnt_q == 4'd1) rstate_d = R_RESP;
            end
            R_RESP: if (r_hs) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read outputs. The SRAM is sampled on the first R_RESP cycle, and the result is then held until the handshake.
    always_comb begin
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (rstate_q == R_RESP) begin
            if (!rvalid_q) begin
                rvalid_d = 1'b1;
                rdata_d  = r_in ? mem[r_idx] : '0;
                rresp_d  = r_in ? OKAY : SLVERR;
            end else if (rready_i) begin
                rvalid_d = 1'b0;
            end
        end
    end

    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

    // ---------------- write channel ----------------
    wstate_t     wstate_q, wstate_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  wstb_q, wstb_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        wr_commit;

    logic                  aw_hs, w_hs, b_hs, w_in, w_go;
    logic [31:0]           woff;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  unused_wstrb_hi;

    assign aw_hs = awvalid_i && awready_q;
    assign w_hs  = wvalid_i && wready_q;
    assign b_hs  = bvalid_q && bready_i;
    assign woff  = waddr_q - BASE;
    assign w_in  = {1'b0, woff} < WIN_BYTES;
    assign w_idx = woff[DEPTH_LOG2+1:2];
    assign unused_wstrb_hi = ^wstrb_i[7:4];

    // Write state, captured AW/W payload and registered write outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            wcnt_q    <= '0;
            waddr_q   <= '0;
            wdat_q    <= '0;
            wstb_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            wstate_q  <= wstate_d;
            wcnt_q    <= wcnt_d;
            waddr_q   <= waddr_d;
            wdat_q    <= wdat_d;
            wstb_q    <= wstb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Write next state: collect AW and W in either order, then start the latency count once both are held.
    always_comb begin
        wstate_d = wstate_q;
        wcnt_d   = wcnt_q;
        waddr_d  = aw_hs ? awaddr_i : waddr_q;
        wdat_d   = w_hs ? wdata_i : wdat_q;
        wstb_d   = w_hs ? wstrb_i[3:0] : wstb_q;
        w_go     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) w_go = 1'b1;
                else if (aw_hs)    wstate_d = W_HAVE_A;
                else if (w_hs)     wstate_d = W_HAVE_D;
            end
            W_HAVE_A: if (w_hs)  w_go = 1'b1;
            W_HAVE_D: if (aw_hs) w_go = 1'b1;
            W_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) wstate_d = W_RESP;
            end
            W_RESP: if (b_hs) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
        if (w_go) begin
            wcnt_d   = WR_CNT;
            wstate_d = (WR_LAT == 0) ? W_RESP : W_WAIT;
        end
    end

    // Write outputs. The SRAM is written on the same edge that raises bvalid, so a write abandoned by reset before W_RESP never lands.
    always_comb begin
        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_D);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_A);
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_commit = 1'b0;
        if (wstate_q == W_RESP) begin
            if (!bvalid_q) begin
                bvalid_d  = 1'b1;
                bresp_d   = w_in ? OKAY : SLVERR;
                wr_commit = w_in;
            end else if (bready_i) begin
                bvalid_d = 1'b0;
            end
        end
    end

    // Byte-masked SRAM write. A read sampled on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstb_q[i]) mem[w_idx][8*i +: 8] <= wdat_q[8*i +: 8];
            end
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave. A byte-level SRAM model and
// response queues supply every expected value.
module tb_axi_lite_sram_slave;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [7:0]  wstrb;

    int checks = 0;
    int fails  = 0;

    logic [31:0] model [int];
    logic [31:0] exp_rdata_q [$];
    logic [1:0]  exp_rresp_q [$];
    logic [1:0]  exp_bresp_q [$];

    axi_lite_sram_slave #(
        .BASE(32'h8000_0000), .DEPTH_LOG2(12), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit tb_in(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h8000_0000;
        return off < 32'h0000_4000;
    endfunction

    function automatic int tb_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'h8000_0000;
        return int'((off >> 2) & 32'h0000_0FFF);
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [7:0] strb, input int lead);
        logic [31:0] cur;
        int n;
        if (tb_in(addr)) begin
            cur = model.exists(tb_idx(addr)) ? model[tb_idx(addr)] : 32'h0;
            for (int i = 0; i < 4; i++) if (strb[i]) cur[8*i +: 8] = data[8*i +: 8];
            model[tb_idx(addr)] = cur;
            exp_bresp_q.push_back(2'b00);
        end else begin
            exp_bresp_q.push_back(2'b10);
        end
        awaddr = addr; awvalid = 1'b1;
        wdata = data;  wstrb = strb;
        wvalid = (lead == 0);
        n = 0;
        while (awready !== 1'b1 && n < 20) begin step(); n++; end
        chk("awready_wait", {31'b0, awready}, 32'd1);
        step();
        awvalid = 1'b0;
        if (lead > 0) begin
            chk("awready_have_a", {31'b0, awready}, 32'd0);
            chk("wready_have_a", {31'b0, wready}, 32'd1);
            repeat (lead - 1) step();
            wvalid = 1'b1;
            step();
        end
        wvalid = 1'b0;
        n = 0;
        while (bvalid !== 1'b1 && n < 60) begin step(); n++; end
        chk("b_latency", 32'(n), 32'(1 + WR_LAT));
        chk("bresp", {30'b0, bresp}, {30'b0, exp_bresp_q.pop_front()});
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_after_b", {31'b0, bvalid}, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold);
        logic [31:0] ed;
        logic [1:0]  er;
        int n;
        if (tb_in(addr)) begin
            exp_rdata_q.push_back(model.exists(tb_idx(addr)) ? model[tb_idx(addr)] : 32'hx);
            exp_rresp_q.push_back(2'b00);
        end else begin
            exp_rdata_q.push_back(32'h0);
            exp_rresp_q.push_back(2'b10);
        end
        araddr = addr; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 20) begin step(); n++; end
        chk("arready_wait", {31'b0, arready}, 32'd1);
        step();
        arvalid = 1'b0;
        n = 0;
        while (rvalid !== 1'b1 && n < 60) begin step(); n++; end
        chk("r_latency", 32'(n), 32'(1 + RD_LAT));
        ed = exp_rdata_q.pop_front();
        er = exp_rresp_q.pop_front();
        chk("rdata", rdata, ed);
        chk("rresp", {30'b0, rresp}, {30'b0, er});
        arvalid = (hold > 0);
        for (int k = 0; k < hold; k++) begin
            step();
            chk("rvalid_hold", {31'b0, rvalid}, 32'd1);
            chk("rdata_hold", rdata, ed);
            chk("arready_hold", {31'b0, arready}, 32'd0);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rvalid_after_r", {31'b0, rvalid}, 32'd0);
        chk("arready_after_r", {31'b0, arready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) step();
        chk("rst_arready", {31'b0, arready}, 32'd0);
        chk("rst_awready", {31'b0, awready}, 32'd0);
        chk("rst_wready", {31'b0, wready}, 32'd0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk) rst = 1'b0;
        step();
        chk("idle_arready", {31'b0, arready}, 32'd1);
        chk("idle_awready", {31'b0, awready}, 32'd1);
        chk("idle_wready", {31'b0, wready}, 32'd1);

        // Full-word write, then read it back.
        do_write(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0);
        do_read (32'h8000_0010, 0);
        // Partial write of byte 1.
        do_write(32'h8000_0010, 32'h0000_AA00, 8'h02, 0);
        do_read (32'h8000_0010, 0);
        // AW leads W by 2 cycles.
        do_write(32'h8000_0020, 32'h1234_5678, 8'h0F, 2);
        do_read (32'h8000_0020, 0);
        // Zero strobes, and upper strobe bits alone: OKAY, no change.
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 8'h00, 0);
        do_write(32'h8000_0020, 32'hFFFF_FFFF, 8'hF0, 0);
        do_read (32'h8000_0020, 0);
        // First and last words, which the out-of-range addresses would alias.
        do_write(32'h8000_0000, 32'hA5A5_0001, 8'h0F, 0);
        do_write(32'h8000_3FFC, 32'h5A5A_0FFF, 8'h0F, 1);
        do_read (32'h8000_3FFC, 0);
        do_read (32'h7FFF_FFFC, 0);
        do_read (32'h8000_4000, 0);
        do_write(32'h7FFF_FFFC, 32'hBAD0_0001, 8'h0F, 0);
        do_write(32'h8000_4000, 32'hBAD0_0002, 8'h0F, 0);
        do_read (32'h8000_0000, 0);
        do_read (32'h8000_3FFC, 0);
        // Backpressure on R for 5 cycles, with a second AR offered.
        do_read (32'h8000_0010, 5);

        // Reset with both FSMs in their wait states.
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0020; wdata = 32'hFFFF_FFFF; wstrb = 8'h0F;
        awvalid = 1'b1; wvalid = 1'b1;
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        chk("wait_arready", {31'b0, arready}, 32'd0);
        chk("wait_awready", {31'b0, awready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_arready", {31'b0, arready}, 32'd0);
        chk("midrst_awready", {31'b0, awready}, 32'd0);
        chk("midrst_wready", {31'b0, wready}, 32'd0);
        chk("midrst_rvalid", {31'b0, rvalid}, 32'd0);
        chk("midrst_bvalid", {31'b0, bvalid}, 32'd0);
        @(negedge clk) rst = 1'b0;
        step();
        chk("post_arready", {31'b0, arready}, 32'd1);
        chk("post_awready", {31'b0, awready}, 32'd1);
        chk("post_wready", {31'b0, wready}, 32'd1);
        repeat (4) step();
        chk("post_bvalid", {31'b0, bvalid}, 32'd0);
        do_read (32'h8000_0020, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
